// File: rtl/alu_issue_pkg.sv
// Shared decode constants for the RV64I ALU issue stage: ALU opcodes,
// base opcodes, register bus width and the decoded-bundle type.
package alu_issue_pkg;

  localparam int unsigned REG_BUS = 64;

  typedef enum logic [3:0] {
    ALUOP_ADD  = 4'b0000,
    ALUOP_SUB  = 4'b0001,
    ALUOP_XOR  = 4'b0100,
    ALUOP_OR   = 4'b0110,
    ALUOP_AND  = 4'b0111,
    ALUOP_SLL  = 4'b1000,
    ALUOP_SRL  = 4'b1001,
    ALUOP_SRA  = 4'b1011,
    ALUOP_SLT  = 4'b1100,
    ALUOP_SLTU = 4'b1110
  } aluop_e;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;

  typedef struct packed {
    aluop_e               aluop;
    logic [REG_BUS-1:0]   op1;
    logic [REG_BUS-1:0]   op2;
    logic [4:0]           rd;
    logic                 rd_we;
    logic                 word;
    logic                 branch;
    logic [2:0]           br_f3;
    logic                 illegal;
  } dec_t;

  // funct3 -> ALU op for the non-alternate OP/OP-IMM encodings
  function automatic aluop_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALUOP_ADD;
      3'b001:  base_op = ALUOP_SLL;
      3'b010:  base_op = ALUOP_SLT;
      3'b011:  base_op = ALUOP_SLTU;
      3'b100:  base_op = ALUOP_XOR;
      3'b101:  base_op = ALUOP_SRL;
      3'b110:  base_op = ALUOP_OR;
      default: base_op = ALUOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV64I decode: instruction, PC and register data to ALU
// opcode, operands and writeback/branch control.
module alu_decode
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = REG_BUS
) (
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output dec_t            dec_o
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      rd;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, sh6, sh5;
  aluop_e          aluop;
  logic [XLEN-1:0] op1, op2;
  logic            we, word, branch, legal;

  assign opc   = inst_i[6:0];
  assign f3    = inst_i[14:12];
  assign f7    = inst_i[31:25];
  assign rd    = inst_i[11:7];
  assign imm_i = {{(XLEN-12){inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{(XLEN-12){inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_u = {{(XLEN-32){inst_i[31]}}, inst_i[31:12], 12'b0};
  assign sh6   = {{(XLEN-6){1'b0}}, inst_i[25:20]};
  assign sh5   = {{(XLEN-5){1'b0}}, inst_i[24:20]};

  always_comb begin
    aluop  = ALUOP_ADD;
    op1    = '0;
    op2    = '0;
    we     = 1'b0;
    word   = 1'b0;
    branch = 1'b0;
    legal  = 1'b1;
    case (opc)
      OPC_OP, OPC_OP32: begin
        op1  = rs1_i;
        op2  = rs2_i;
        we   = 1'b1;
        word = (opc == OPC_OP32);
        if (f7 == 7'b0000000)                         aluop = base_op(f3);
        else if (f7 == 7'b0100000 && f3 == 3'b000)    aluop = ALUOP_SUB;
        else if (f7 == 7'b0100000 && f3 == 3'b101)    aluop = ALUOP_SRA;
        else                                          legal = 1'b0;
        if (word && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101)) legal = 1'b0;
      end
      OPC_OPIMM: begin
        op1   = rs1_i;
        op2   = imm_i;
        we    = 1'b1;
        aluop = base_op(f3);
        if (f3 == 3'b001 || f3 == 3'b101) begin
          op2 = sh6;
          if (inst_i[31:26] == 6'b010000 && f3 == 3'b101) aluop = ALUOP_SRA;
          else if (inst_i[31:26] != 6'b000000)            legal = 1'b0;
        end
      end
      OPC_OPIMM32: begin
        op1   = rs1_i;
        we    = 1'b1;
        word  = 1'b1;
        aluop = base_op(f3);
        case (f3)
          3'b000: op2 = imm_i;
          // 5-bit shamt: a set inst[25] lands in funct7 and fails the check
          3'b001, 3'b101: begin
            op2 = sh5;
            if (f7 == 7'b0100000 && f3 == 3'b101) aluop = ALUOP_SRA;
            else if (f7 != 7'b0000000)            legal = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        op2 = imm_u;
        we  = 1'b1;
      end
      OPC_AUIPC: begin
        op1 = pc_i;
        op2 = imm_u;
        we  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        op1 = pc_i;
        op2 = XLEN'(4);
        we  = 1'b1;
        if (opc == OPC_JALR && f3 != 3'b000) legal = 1'b0;
      end
      OPC_LOAD: begin
        op1   = rs1_i;
        op2   = imm_i;
        we    = 1'b1;
        legal = (f3 != 3'b111);
      end
      OPC_STORE: begin
        op1   = rs1_i;
        op2   = imm_s;
        legal = !f3[2];
      end
      OPC_BRANCH: begin
        op1    = rs1_i;
        op2    = rs2_i;
        branch = 1'b1;
        case (f3[2:1])
          2'b00:   aluop = ALUOP_SUB;
          2'b10:   aluop = ALUOP_SLT;
          2'b11:   aluop = ALUOP_SLTU;
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    dec_o    = '0;
    dec_o.rd = rd;
    if (legal) begin
      dec_o.aluop  = aluop;
      dec_o.op1    = op1;
      dec_o.op2    = op2;
      dec_o.rd_we  = we && (rd != 5'd0);
      dec_o.word   = word;
      dec_o.branch = branch;
      dec_o.br_f3  = branch ? f3 : 3'b000;
    end else begin
      dec_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Operand-issue stage: decodes one instruction per handshake and holds the
// result in a single-entry valid/ready register feeding execute.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned XLEN = REG_BUS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_aluop,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_word,
  output logic            out_branch,
  output logic [2:0]      out_br_f3,
  output logic            out_illegal
);

  dec_t            dec_d, dec_q;
  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  alu_decode #(.XLEN(XLEN)) u_decode (
    .inst_i (in_inst),
    .pc_i   (in_pc),
    .rs1_i  (rs1_data),
    .rs2_i  (rs2_data),
    .dec_o  (dec_d)
  );

  assign in_ready = !valid_q || out_ready;

  // flush wins over a same-cycle transfer; payload only loads on a kept transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
      pc_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q <= 1'b1;
      dec_q   <= dec_d;
      pc_q    <= in_pc;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_aluop   = dec_q.aluop;
  assign out_op1     = dec_q.op1;
  assign out_op2     = dec_q.op2;
  assign out_pc      = pc_q;
  assign out_rd      = dec_q.rd;
  assign out_rd_we   = dec_q.rd_we;
  assign out_word    = dec_q.word;
  assign out_branch  = dec_q.branch;
  assign out_br_f3   = dec_q.br_f3;
  assign out_illegal = dec_q.illegal;

endmodule
